// File: rtl/chave_scan.sv
// chave_scan: debounced switch selector and round-robin change-event reporter.
//
// Ports:
//   clk        in   single clock, all state updates on its rising edge
//   rst_n      in   synchronous active-low reset
//   ch         in   N_CH raw asynchronous switch inputs
//   esp_sel    in   SEL_W channel index selecting the level driven on s
//   mode       in   0 = select only, 1 = select plus change events
//   s          out  registered debounced level of channel esp_sel (0 if out of range)
//   evt_valid  out  change event available
//   evt_ready  in   ESP side accepts the current event
//   evt_ch     out  SEL_W index of the changed channel
//   evt_level  out  debounced level of evt_ch captured when the event was loaded
module chave_scan #(
    parameter int N_CH = 16,
    parameter int DEB_CYCLES = 4,
    localparam int SEL_W = $clog2(N_CH),
    localparam int CNT_W = $clog2(DEB_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_CH-1:0]  ch,
    input  logic [SEL_W-1:0] esp_sel,
    input  logic             mode,
    output logic             s,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [SEL_W-1:0] evt_ch,
    output logic             evt_level
);
    logic [N_CH-1:0]  meta;
    logic [N_CH-1:0]  sync;
    logic [N_CH-1:0]  deb;
    logic [N_CH-1:0]  flip;
    logic [N_CH-1:0]  pend;
    logic [CNT_W-1:0] cnt [N_CH];
    logic [SEL_W-1:0] last;
    logic [SEL_W-1:0] pick;
    logic [SEL_W-1:0] cand;
    logic             found;
    logic             load;

    // A channel flips on the cycle its counter has already seen DEB_CYCLES-1
    // disagreeing cycles and the input still disagrees.
    always_comb begin
        flip = '0;
        for (int i = 0; i < N_CH; i++)
            flip[i] = (sync[i] != deb[i]) && (cnt[i] == CNT_W'(DEB_CYCLES - 1));
    end

    // Round-robin search: first pending channel strictly after last, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = last;
        cand  = '0;
        for (int k = 1; k <= N_CH; k++) begin
            cand = SEL_W'((int'(last) + k) % N_CH);
            if (!found && pend[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign load = mode && found && (!evt_valid || evt_ready);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta      <= '0;
            sync      <= '0;
            deb       <= '0;
            pend      <= '0;
            last      <= SEL_W'(N_CH - 1);
            s         <= 1'b0;
            evt_valid <= 1'b0;
            evt_ch    <= '0;
            evt_level <= 1'b0;
            for (int i = 0; i < N_CH; i++)
                cnt[i] <= '0;
        end else begin
            meta <= ch;
            sync <= meta;
            deb  <= deb ^ flip;
            for (int i = 0; i < N_CH; i++)
                cnt[i] <= (sync[i] == deb[i] || flip[i]) ? '0 : cnt[i] + CNT_W'(1);
            s <= ({1'b0, esp_sel} < (SEL_W + 1)'(N_CH)) ? deb[esp_sel] : 1'b0;
            // New flips are OR-ed after the load clear so a change seen on the
            // loading cycle re-arms the channel.
            pend <= mode ? ((pend & ~(load ? (N_CH'(1) << pick) : '0)) | flip) : '0;
            if (load) begin
                evt_valid <= 1'b1;
                evt_ch    <= pick;
                evt_level <= deb[pick];
                last      <= pick;
            end else if (evt_ready) begin
                evt_valid <= 1'b0;
            end
        end
    end
endmodule
